// File: rtl/pcie_datalink_pkg.sv
// pcie_datalink_pkg: DLLP type codes, field extractors and the DLLP CRC16 function
package pcie_datalink_pkg;

   typedef enum logic [7:0] {
      DllpAck        = 8'h00,
      DllpNak        = 8'h10,
      DllpInitFc1P   = 8'h40,
      DllpInitFc1Np  = 8'h50,
      DllpInitFc1Cpl = 8'h60,
      DllpUpdFcP     = 8'h80,
      DllpUpdFcNp    = 8'h90,
      DllpUpdFcCpl   = 8'hA0,
      DllpInitFc2P   = 8'hC0,
      DllpInitFc2Np  = 8'hD0,
      DllpInitFc2Cpl = 8'hE0
   } dllp_type_t;

   localparam logic [3:0] TypeInitFc1P   = 4'h4;
   localparam logic [3:0] TypeInitFc1Np  = 4'h5;
   localparam logic [3:0] TypeInitFc1Cpl = 4'h6;
   localparam logic [3:0] TypeInitFc2P   = 4'hC;
   localparam logic [3:0] TypeInitFc2Np  = 4'hD;
   localparam logic [3:0] TypeInitFc2Cpl = 4'hE;
   localparam logic [3:0] TypeUpdFcP     = 4'h8;
   localparam logic [3:0] TypeUpdFcNp    = 4'h9;
   localparam logic [3:0] TypeUpdFcCpl   = 4'hA;

   // dw packs DLLP bytes little-endian: byte0 in [7:0] .. byte3 in [31:24]
   function automatic logic [11:0] get_ack_nack_seq(input logic [31:0] dw);
      return {dw[19:16], dw[31:24]};
   endfunction

   function automatic logic [7:0] get_fc_hdr(input logic [31:0] dw);
      return {dw[13:8], dw[23:22]};
   endfunction

   function automatic logic [11:0] get_fc_data(input logic [31:0] dw);
      return {dw[19:16], dw[31:24]};
   endfunction

   // Bits enter LSB-first per byte; the complemented remainder is bit-reversed so
   // the result lines up as {byte5,byte4} on the wire.
   function automatic logic [15:0] dllp_crc16(input logic [31:0] dw);
      logic [15:0] c;
      c = 16'hFFFF;
      for (int i = 0; i < 4; i++)
         for (int j = 0; j < 8; j++)
            c = {c[14:0], 1'b0} ^ ({16{c[15] ^ dw[8*i+j]}} & 16'h100B);
      return {<<{~c}};
   endfunction

endpackage

// File: rtl/pcie_dllp_crc16.sv
// pcie_dllp_crc16: combinational CRC16 over the four DLLP payload bytes
module pcie_dllp_crc16
   import pcie_datalink_pkg::*;
(
   input  logic [31:0] data,
   output logic [15:0] crc
);
   assign crc = dllp_crc16(data);
endmodule

// File: rtl/pcie_dllp_rx.sv
// pcie_dllp_rx: reassembles 2-beat DLLPs, checks CRC, decodes Ack/Nak/FC and tracks VC0 FC init
module pcie_dllp_rx
   import pcie_datalink_pkg::*;
#(
   parameter bit CHECK_CRC = 1'b1,
   parameter int CNT_WIDTH = 16
)(
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 link_up,
   input  logic [31:0]          s_axis_tdata,
   input  logic [3:0]           s_axis_tkeep,
   input  logic                 s_axis_tvalid,
   input  logic                 s_axis_tlast,
   output logic                 s_axis_tready,
   output logic                 ack_valid,
   output logic                 nak_valid,
   output logic [11:0]          acknak_seq,
   output logic                 fc_valid,
   output dllp_type_t           fc_type,
   output logic [2:0]           fc_vc,
   output logic [7:0]           fc_hdr,
   output logic [11:0]          fc_data,
   output logic [2:0]           fc_seen,
   output logic                 fc_init_done,
   output logic [CNT_WIDTH-1:0] crc_err_cnt,
   output logic [CNT_WIDTH-1:0] frame_err_cnt
);
   typedef enum logic [1:0] {IDLE, BEAT1, DISCARD} state_t;

   state_t      state, state_nxt;
   logic        beat, frame_err, load0, load1, crc_ok, bad_crc;
   logic        pend_vld, is_ack, is_nak, is_fc, is_init;
   logic [31:0] dw_q, pend_dw;
   logic [15:0] crc_calc;
   logic [3:0]  nib;
   logic [2:0]  seen_set;
   logic        unused_bits;

   pcie_dllp_crc16 u_crc (.data(dw_q), .crc(crc_calc));

   assign beat        = s_axis_tvalid & s_axis_tready;
   assign load0       = beat && state == IDLE && !s_axis_tlast && s_axis_tkeep == 4'hF;
   assign load1       = beat && state == BEAT1 && s_axis_tlast && s_axis_tkeep[1:0] == 2'b11;
   assign crc_ok      = s_axis_tdata[15:0] == crc_calc;
   assign bad_crc     = load1 & CHECK_CRC & ~crc_ok;
   assign unused_bits = ^s_axis_tdata[31:16];

   assign nib      = pend_dw[7:4];
   assign is_ack   = pend_dw[7:0] == 8'h00;
   assign is_nak   = pend_dw[7:0] == 8'h10;
   assign is_init  = nib inside {TypeInitFc1P, TypeInitFc1Np, TypeInitFc1Cpl,
                                 TypeInitFc2P, TypeInitFc2Np, TypeInitFc2Cpl};
   assign is_fc    = is_init | (nib inside {TypeUpdFcP, TypeUpdFcNp, TypeUpdFcCpl});
   assign seen_set = (pend_vld && is_init && pend_dw[2:0] == 3'd0) ? 3'b001 << pend_dw[5:4] : 3'b000;
   assign fc_init_done = &fc_seen;

   // framing state register
   always_ff @(posedge clk or posedge rst)
      if (rst) state <= IDLE;
      else     state <= state_nxt;

   // framing next-state and frame-error detection
   always_comb begin
      state_nxt = state;
      frame_err = 1'b0;
      if (beat)
         case (state)
            IDLE: begin
               frame_err = s_axis_tlast | (s_axis_tkeep != 4'hF);
               state_nxt = s_axis_tlast ? IDLE : (s_axis_tkeep == 4'hF ? BEAT1 : DISCARD);
            end
            BEAT1: begin
               frame_err = !s_axis_tlast || s_axis_tkeep[1:0] != 2'b11;
               state_nxt = s_axis_tlast ? IDLE : DISCARD;
            end
            default: state_nxt = s_axis_tlast ? IDLE : DISCARD;
         endcase
   end

   // payload capture, CRC-checked staging register and error counters
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         dw_q          <= '0;
         pend_dw       <= '0;
         pend_vld      <= 1'b0;
         crc_err_cnt   <= '0;
         frame_err_cnt <= '0;
      end else begin
         if (load0) dw_q <= s_axis_tdata;
         if (load1) pend_dw <= dw_q;
         pend_vld      <= load1 & ~bad_crc;
         crc_err_cnt   <= crc_err_cnt + CNT_WIDTH'(bad_crc & ~&crc_err_cnt);
         frame_err_cnt <= frame_err_cnt + CNT_WIDTH'(frame_err & ~&frame_err_cnt);
      end

   // decoded event pulses, held fields and VC0 init tracking
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         s_axis_tready <= 1'b0;
         ack_valid     <= 1'b0;
         nak_valid     <= 1'b0;
         fc_valid      <= 1'b0;
         acknak_seq    <= '0;
         fc_type       <= DllpAck;
         fc_vc         <= '0;
         fc_hdr        <= '0;
         fc_data       <= '0;
         fc_seen       <= '0;
      end else begin
         s_axis_tready <= 1'b1;
         ack_valid     <= pend_vld & is_ack;
         nak_valid     <= pend_vld & is_nak;
         fc_valid      <= pend_vld & is_fc;
         if (pend_vld && (is_ack || is_nak)) acknak_seq <= get_ack_nack_seq(pend_dw);
         if (pend_vld && is_fc) begin
            fc_type <= dllp_type_t'({nib, 4'h0});
            fc_vc   <= pend_dw[2:0];
            fc_hdr  <= get_fc_hdr(pend_dw);
            fc_data <= get_fc_data(pend_dw);
         end
         fc_seen <= link_up ? (fc_seen | seen_set) : 3'b000;
      end
endmodule

// File: tb/tb_pcie_dllp_rx.sv
// tb_pcie_dllp_rx: directed checks of DLLP reassembly, CRC, decode, FC init and framing errors
module tb_pcie_dllp_rx;
   import pcie_datalink_pkg::*;

   logic        clk = 1'b0, rst = 1'b1, link_up = 1'b1;
   logic [31:0] s_axis_tdata = '0;
   logic [3:0]  s_axis_tkeep = '0;
   logic        s_axis_tvalid = 1'b0, s_axis_tlast = 1'b0;
   logic        s_axis_tready, ack_valid, nak_valid, fc_valid, fc_init_done;
   logic [11:0] acknak_seq, fc_data;
   dllp_type_t  fc_type;
   logic [2:0]  fc_vc, fc_seen;
   logic [7:0]  fc_hdr;
   logic [15:0] crc_err_cnt, frame_err_cnt;
   int checks = 0, errors = 0;

   pcie_dllp_rx dut (
      .clk(clk), .rst(rst), .link_up(link_up),
      .s_axis_tdata(s_axis_tdata), .s_axis_tkeep(s_axis_tkeep),
      .s_axis_tvalid(s_axis_tvalid), .s_axis_tlast(s_axis_tlast), .s_axis_tready(s_axis_tready),
      .ack_valid(ack_valid), .nak_valid(nak_valid), .acknak_seq(acknak_seq),
      .fc_valid(fc_valid), .fc_type(fc_type), .fc_vc(fc_vc), .fc_hdr(fc_hdr), .fc_data(fc_data),
      .fc_seen(fc_seen), .fc_init_done(fc_init_done),
      .crc_err_cnt(crc_err_cnt), .frame_err_cnt(frame_err_cnt)
   );

   always #5 clk = ~clk;

   // Reference CRC: one message bit at a time in wire order (byte0 bit0 first),
   // then complement and full 16-bit reversal into {byte5,byte4}.
   function automatic logic [15:0] crc_model(input logic [31:0] d);
      logic [15:0] c, r;
      c = 16'hFFFF;
      for (int k = 0; k < 32; k++) c = (c << 1) ^ (((c[15] ^ d[k]) == 1'b1) ? 16'h100B : 16'h0000);
      c = ~c;
      for (int j = 0; j < 16; j++) r[j] = c[15 - j];
      return r;
   endfunction

   function automatic logic [31:0] acknak_dw(input logic [7:0] t, input logic [11:0] seq);
      return {seq[7:0], 4'h0, seq[11:8], 8'h00, t};
   endfunction

   function automatic logic [31:0] fc_dw(input logic [7:0] t, input logic [2:0] vc,
                                         input logic [7:0] hdr, input logic [11:0] data);
      return {data[7:0], hdr[1:0], 2'b00, data[11:8], 2'b00, hdr[7:2], t | {5'd0, vc}};
   endfunction

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic beat(input logic [31:0] d, input logic [3:0] k, input logic l);
      @(negedge clk);
      s_axis_tdata = d; s_axis_tkeep = k; s_axis_tlast = l; s_axis_tvalid = 1'b1;
      @(posedge clk);
      #1;
      s_axis_tvalid = 1'b0;
   endtask

   task automatic send(input logic [31:0] dw, input logic [15:0] flip);
      beat(dw, 4'hF, 1'b0);
      beat({16'h0000, crc_model(dw) ^ flip}, 4'h3, 1'b1);
   endtask

   initial begin
      repeat (3) @(posedge clk);
      #1;
      chk("tready_in_reset", 32'(s_axis_tready), 0);
      chk("seq_in_reset", 32'(acknak_seq), 0);
      @(negedge clk) rst = 1'b0;
      step();
      chk("tready_after_reset", 32'(s_axis_tready), 1);

      send(acknak_dw(8'h00, 12'h5A3), 16'h0);
      chk("ack_not_yet", 32'(ack_valid), 0);
      step();
      chk("ack_pulse", 32'(ack_valid), 1);
      chk("ack_no_nak", 32'(nak_valid), 0);
      chk("ack_no_fc", 32'(fc_valid), 0);
      chk("ack_seq", 32'(acknak_seq), 32'h5A3);
      step();
      chk("ack_pulse_end", 32'(ack_valid), 0);
      chk("ack_seq_hold", 32'(acknak_seq), 32'h5A3);

      for (int i = 0; i < 3; i++) begin
         send(fc_dw(8'h40 + 8'(i * 16), 3'd0, 8'h01, 12'h040), 16'h0);
         step();
         chk("initfc1_valid", 32'(fc_valid), 1);
         chk("initfc1_type", 32'(fc_type), 32'h40 + 32'(i * 16));
         chk("initfc1_hdr", 32'(fc_hdr), 32'h01);
         chk("initfc1_data", 32'(fc_data), 32'h040);
         chk("initfc1_seen", 32'(fc_seen), (32'd2 << i) - 32'd1);
      end
      chk("init_done", 32'(fc_init_done), 1);

      send(acknak_dw(8'h10, 12'h123), 16'h0001);
      chk("crc_err_cnt", 32'(crc_err_cnt), 1);
      step();
      chk("bad_nak_no_pulse", 32'(nak_valid), 0);
      step();
      chk("bad_nak_no_pulse2", 32'(nak_valid), 0);
      send(acknak_dw(8'h10, 12'h123), 16'h0);
      step();
      chk("nak_pulse", 32'(nak_valid), 1);
      chk("nak_seq", 32'(acknak_seq), 32'h123);
      chk("crc_err_stable", 32'(crc_err_cnt), 1);

      beat(32'hDEADBEEF, 4'hF, 1'b1);
      chk("frame_err_tlast0", 32'(frame_err_cnt), 1);
      beat(acknak_dw(8'h00, 12'h001), 4'hF, 1'b0);
      beat(32'h0, 4'hF, 1'b0);
      chk("frame_err_nolast", 32'(frame_err_cnt), 2);
      beat(32'h0, 4'h3, 1'b1);
      chk("discard_no_pulse", 32'(ack_valid), 0);
      send(acknak_dw(8'h00, 12'h001), 16'h0);
      step();
      chk("ack_after_frame", 32'(ack_valid), 1);
      chk("seq_after_frame", 32'(acknak_seq), 32'h001);
      chk("frame_err_stable", 32'(frame_err_cnt), 2);

      @(negedge clk) link_up = 1'b0;
      step();
      chk("seen_cleared", 32'(fc_seen), 0);
      chk("done_cleared", 32'(fc_init_done), 0);
      link_up = 1'b1;
      send(fc_dw(8'h40, 3'd1, 8'h22, 12'h345), 16'h0);
      step();
      chk("vc1_valid", 32'(fc_valid), 1);
      chk("vc1_vc", 32'(fc_vc), 1);
      chk("vc1_hdr", 32'(fc_hdr), 32'h22);
      chk("vc1_data", 32'(fc_data), 32'h345);
      chk("vc1_seen", 32'(fc_seen), 0);
      send(fc_dw(8'h80, 3'd0, 8'h10, 12'h200), 16'h0);
      step();
      chk("updfc_type", 32'(fc_type), 32'h80);
      chk("updfc_seen", 32'(fc_seen), 0);
      send(fc_dw(8'hE0, 3'd0, 8'h01, 12'h001), 16'h0);
      step();
      chk("initfc2_cpl_seen", 32'(fc_seen), 32'b100);
      send(acknak_dw(8'h20, 12'h0AB), 16'h0);
      step();
      chk("pm_no_ack", 32'(ack_valid), 0);
      chk("pm_no_fc", 32'(fc_valid), 0);

      beat(acknak_dw(8'h00, 12'h0F0), 4'hF, 1'b0);
      rst = 1'b1;
      #1;
      chk("rst_seq", 32'(acknak_seq), 0);
      chk("rst_seen", 32'(fc_seen), 0);
      chk("rst_crc_cnt", 32'(crc_err_cnt), 0);
      chk("rst_frame_cnt", 32'(frame_err_cnt), 0);
      chk("rst_tready", 32'(s_axis_tready), 0);
      @(negedge clk) rst = 1'b0;
      step();
      send(acknak_dw(8'h00, 12'h7FF), 16'h0);
      step();
      chk("post_rst_ack", 32'(ack_valid), 1);
      chk("post_rst_seq", 32'(acknak_seq), 32'h7FF);
      chk("post_rst_frame", 32'(frame_err_cnt), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
